// File: rtl/framebuffer_write_arbiter.sv
// framebuffer_write_arbiter
//   Owns the single write port of the 1-bit-per-pixel framebuffer and shares
//   it between CPU single-pixel writes and a rectangle-fill engine that paints
//   a clipped rectangle at one pixel per granted cycle.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   px_valid/px_ready        CPU pixel-write handshake
//   px_x, px_y, px_color     pixel coordinate and value
//   fill_valid/fill_ready    fill-command handshake (accepted only when idle)
//   fill_x0..fill_y1         inclusive rectangle corners, fill_color its value
//   fill_busy                fill in progress (held through the done cycle)
//   fill_done                one-cycle pulse when a fill completes
//   fb_we, fb_addr, fb_din   registered framebuffer write port
module framebuffer_write_arbiter #(
  parameter int WIDTH      = 800,
  parameter int HEIGHT     = 600,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  px_valid,
  output logic                  px_ready,
  input  logic [9:0]            px_x,
  input  logic [9:0]            px_y,
  input  logic                  px_color,
  input  logic                  fill_valid,
  output logic                  fill_ready,
  input  logic [9:0]            fill_x0,
  input  logic [9:0]            fill_y0,
  input  logic [9:0]            fill_x1,
  input  logic [9:0]            fill_y1,
  input  logic                  fill_color,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic                  fb_din
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic            GRANT_PIXEL = 1'b0;
  localparam logic            GRANT_FILL  = 1'b1;
  localparam logic [9:0]      X_MAX       = 10'(WIDTH - 1);
  localparam logic [9:0]      Y_MAX       = 10'(HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE  = ADDR_WIDTH'(WIDTH);

  state_t                  state_reg, state_next;
  logic                    last_grant_reg;

  logic [9:0]              x0_reg, cx1_reg, cy1_reg, cur_x_reg, cur_y_reg;
  logic                    color_reg;
  logic [ADDR_WIDTH-1:0]   row_base_reg;

  logic                    fb_we_reg, fb_din_reg, fill_busy_reg, fill_done_reg;
  logic [ADDR_WIDTH-1:0]   fb_addr_reg;

  logic                    px_fire, fill_fire, fill_grant, contended;
  logic                    fill_empty, px_in_range, row_end, fill_last;
  logic [9:0]              clip_x1, clip_y1;
  logic [ADDR_WIDTH-1:0]   px_addr, fill_addr;

  // Handshake and grant decode. In RUN the pixel wins a contended cycle only
  // when the fill won the previous one, giving strict alternation.
  assign fill_ready = !rst && (state_reg == IDLE);
  assign px_ready   = !rst && ((state_reg == IDLE) || (last_grant_reg == GRANT_FILL));
  assign px_fire    = px_valid && px_ready;
  assign fill_fire  = fill_valid && fill_ready;
  assign contended  = (state_reg == RUN) && px_valid;
  assign fill_grant = (state_reg == RUN) && !px_fire;

  // Clip the far corner to the visible area; the near corner cannot be
  // clipped, so an off-screen near corner yields an empty fill.
  assign clip_x1    = (fill_x1 > X_MAX) ? X_MAX : fill_x1;
  assign clip_y1    = (fill_y1 > Y_MAX) ? Y_MAX : fill_y1;
  assign fill_empty = (fill_x0 > clip_x1) || (fill_y0 > clip_y1) ||
                      (fill_x0 > X_MAX) || (fill_y0 > Y_MAX);

  assign px_in_range = (px_x <= X_MAX) && (px_y <= Y_MAX);
  assign px_addr     = ADDR_WIDTH'(px_y) * LINE + ADDR_WIDTH'(px_x);
  assign fill_addr   = row_base_reg + ADDR_WIDTH'(cur_x_reg);
  assign row_end     = (cur_x_reg == cx1_reg);
  assign fill_last   = row_end && (cur_y_reg == cy1_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (fill_fire && !fill_empty) state_next = RUN;
      RUN:     if (fill_grant && fill_last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_PIXEL;
    end else begin
      state_reg <= state_next;
      if (contended)
        last_grant_reg <= px_fire ? GRANT_PIXEL : GRANT_FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_we_reg     <= 1'b0;
      fb_addr_reg   <= '0;
      fb_din_reg    <= 1'b0;
      fill_busy_reg <= 1'b0;
      fill_done_reg <= 1'b0;
      x0_reg        <= '0;
      cx1_reg       <= '0;
      cy1_reg       <= '0;
      cur_x_reg     <= '0;
      cur_y_reg     <= '0;
      color_reg     <= 1'b0;
      row_base_reg  <= '0;
    end else begin
      fb_we_reg     <= 1'b0;
      fill_done_reg <= 1'b0;
      // Busy stays up through the cycle that carries the final write.
      fill_busy_reg <= (state_next == RUN) || (fill_grant && fill_last);

      if (px_fire && px_in_range) begin
        fb_we_reg   <= 1'b1;
        fb_addr_reg <= px_addr;
        fb_din_reg  <= px_color;
      end

      if (fill_fire) begin
        if (fill_empty) begin
          fill_done_reg <= 1'b1;
        end else begin
          x0_reg       <= fill_x0;
          cx1_reg      <= clip_x1;
          cy1_reg      <= clip_y1;
          color_reg    <= fill_color;
          cur_x_reg    <= fill_x0;
          cur_y_reg    <= fill_y0;
          row_base_reg <= ADDR_WIDTH'(fill_y0) * LINE;
        end
      end

      // The fill walks the rectangle incrementally: row_base advances by one
      // line per row instead of recomputing y*WIDTH.
      if (fill_grant) begin
        fb_we_reg   <= 1'b1;
        fb_addr_reg <= fill_addr;
        fb_din_reg  <= color_reg;
        if (row_end) begin
          if (fill_last) begin
            fill_done_reg <= 1'b1;
          end else begin
            cur_x_reg    <= x0_reg;
            cur_y_reg    <= cur_y_reg + 10'd1;
            row_base_reg <= row_base_reg + LINE;
          end
        end else begin
          cur_x_reg <= cur_x_reg + 10'd1;
        end
      end
    end
  end

  assign fb_we     = fb_we_reg;
  assign fb_addr   = fb_addr_reg;
  assign fb_din    = fb_din_reg;
  assign fill_busy = fill_busy_reg;
  assign fill_done = fill_done_reg;

endmodule
